// File: rtl/snn_pkg.sv
// Shared SPI register-slave definitions: frame geometry, FSM encoding and
// the named configuration register addresses.
package snn_pkg;

  localparam int SPI_FRAME_BITS = 16;
  localparam int SPI_ADDR_W     = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } spi_state_e;

  localparam logic [SPI_ADDR_W-1:0] REG_CTRL    = 7'h00;
  localparam logic [SPI_ADDR_W-1:0] REG_STATUS  = 7'h01;
  localparam logic [SPI_ADDR_W-1:0] REG_GAIN    = 7'h03;
  localparam logic [SPI_ADDR_W-1:0] REG_THRESH  = 7'h05;
  localparam logic [SPI_ADDR_W-1:0] REG_SCRATCH = 7'h0F;

  function automatic logic addr_in_range(input logic [SPI_ADDR_W-1:0] addr, input int num_regs);
    return int'(addr) < num_regs;
  endfunction

endpackage

// File: rtl/spi_reg_slave_sync2.sv
// Two-flop synchronizer; RST_VAL is the idle level of the incoming signal.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave exposing NUM_REGS 8-bit configuration registers through
// 16-bit frames: {W, addr[6:0], data[7:0]}, MSB first.
module spi_reg_slave
  import snn_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sclk,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic [NUM_REGS*8-1:0]   regs_flat,
  output logic                    wr_valid,
  output logic [SPI_ADDR_W-1:0]   wr_addr,
  output logic [7:0]              wr_data
);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_q, cs_q;

  sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .reset(reset), .d(sclk), .q(sclk_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .reset(reset), .d(cs_n), .q(cs_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset(reset), .d(mosi), .q(mosi_s));

  logic sclk_rise, sclk_fall, cs_fall;
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = cs_q & ~cs_s;

  spi_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [14:0] rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        load_q, load_d;
  logic        read_q, read_d;
  logic        miso_q, miso_d;
  logic        wr_valid_q, wr_valid_d;
  logic [SPI_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  rd_byte;

  // Out-of-range addresses match no register, so they read back as zero.
  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rx_q[6:0] == 7'(i)) rd_byte = regs_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    load_d     = 1'b0;
    read_d     = read_q;
    miso_d     = miso_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (cs_fall) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (sclk_rise) begin
          rx_d  = {rx_q[13:0], mosi_s};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_d = ST_DATA;
            read_d  = ~rx_q[6];
            load_d  = ~rx_q[6];
          end
        end
      end
      ST_DATA: begin
        if (sclk_rise) begin
          rx_d  = {rx_q[13:0], mosi_s};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(SPI_FRAME_BITS - 1)) begin
            state_d = ST_DRAIN;
            cnt_d   = 4'd0;
            if (rx_q[14] && addr_in_range(rx_q[13:7], NUM_REGS)) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = rx_q[13:7];
              wr_data_d  = {rx_q[6:0], mosi_s};
            end
          end
        end
        // Bit 7 is already on miso from the load; shift only after rise 9 onward.
        if (sclk_fall && read_q && cnt_q >= 4'd9) begin
          tx_d   = {tx_q[6:0], 1'b0};
          miso_d = tx_q[6];
        end
        if (load_q) begin
          tx_d   = rd_byte;
          miso_d = rd_byte[7];
        end
      end
      ST_DRAIN: ;
      default: state_d = ST_IDLE;
    endcase

    if (cs_s) begin
      state_d    = ST_IDLE;
      cnt_d      = 4'd0;
      wr_valid_d = 1'b0;
    end
    if (state_d != ST_DATA || !read_d) miso_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      rx_q       <= '0;
      tx_q       <= '0;
      load_q     <= 1'b0;
      read_q     <= 1'b0;
      miso_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      sclk_q     <= sclk_s;
      cs_q       <= cs_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      load_q     <= load_d;
      read_q     <= read_d;
      miso_q     <= miso_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Register update lands on the same edge that raises wr_valid.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      always_ff @(posedge clk) begin
        if (reset) begin
          regs_q[gi] <= 8'h00;
        end else if (wr_valid_d && wr_addr_d == 7'(gi)) begin
          regs_q[gi] <= wr_data_d;
        end
      end
      assign regs_flat[gi*8 +: 8] = regs_q[gi];
    end
  endgenerate

  assign miso     = miso_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: write/read scoreboards plus register model.
module tb_spi_reg_slave;

  localparam int NUM_REGS = 16;
  localparam int HALF     = 60;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  sclk = 1'b0;
  logic                  cs_n = 1'b1;
  logic                  mosi = 1'b0;
  logic                  miso;
  logic [NUM_REGS*8-1:0] regs_flat;
  logic                  wr_valid;
  logic [6:0]            wr_addr;
  logic [7:0]            wr_data;

  spi_reg_slave #(.NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .regs_flat(regs_flat), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [14:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  model [NUM_REGS];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    logic [NUM_REGS*8-1:0] e;
    for (int i = 0; i < NUM_REGS; i++) e[8*i +: 8] = model[i];
    check(tag, regs_flat, e);
  endtask

  // Write scoreboard: each wr_valid cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && wr_valid) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_wr_valid", {wr_addr, wr_data}, 15'h7FFF);
      end else begin
        logic [14:0] e;
        e = exp_wr.pop_front();
        check("wr_addr_data", {wr_addr, wr_data}, e);
      end
    end
  end

  task automatic spi_xfer(input logic [15:0] frame, input int nbits, input int extra,
                          input int rst_after, output logic [7:0] rd);
    logic is_rd;
    is_rd = ~frame[15];
    rd = 8'h00;
    @(negedge clk);
    cs_n = 1'b0;
    #HALF;
    for (int i = 0; i < nbits + extra; i++) begin
      mosi = (i < 16) ? frame[15-i] : 1'($urandom_range(0, 1));
      #HALF;
      sclk = 1'b1;
      if (is_rd && i >= 8 && i < 16) rd[15-i] = miso;
      else check("miso_zero", miso, 1'b0);
      #HALF;
      sclk = 1'b0;
      if (i + 1 == rst_after) begin
        reset = 1'b1;
        #10;
        reset = 1'b0;
      end
    end
    #HALF;
    cs_n = 1'b1;
    mosi = 1'b0;
    #(4*HALF);
    check("miso_cs_high", miso, 1'b0);
  endtask

  task automatic do_read(input logic [6:0] addr, input string tag);
    logic [7:0] rd;
    exp_rd.push_back(int'(addr) < NUM_REGS ? model[addr[3:0]] : 8'h00);
    spi_xfer({1'b0, addr, 8'h00}, 16, 0, 0, rd);
    check(tag, rd, exp_rd.pop_front());
  endtask

  initial begin
    logic [7:0] rd;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_miso", miso, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("init_wr_addr", wr_addr, 7'h00);
    check("init_wr_data", wr_data, 8'h00);
    check_regs("init_regs");

    // Write addr 5 = 0x3C, then read it back.
    exp_wr.push_back({7'd5, 8'h3C});
    model[5] = 8'h3C;
    spi_xfer(16'h853C, 16, 0, 0, rd);
    check("wr5_regs", regs_flat[47:40], 8'h3C);
    check_regs("wr5_all");
    do_read(7'd5, "rd5");
    check_regs("rd5_no_side_effect");

    // Out-of-range write is dropped; out-of-range read returns zero.
    spi_xfer(16'h92FF, 16, 0, 0, rd);
    check_regs("oob_wr_regs");
    do_read(7'h12, "rd_oob");

    // Truncated frame is discarded, full frame then commits.
    spi_xfer(16'h83AA, 12, 0, 0, rd);
    check_regs("partial_regs");
    exp_wr.push_back({7'd3, 8'hAA});
    model[3] = 8'hAA;
    spi_xfer(16'h83AA, 16, 0, 0, rd);
    check_regs("wr3_regs");
    do_read(7'd3, "rd3");

    // Reset after 10 bits aborts the frame and clears everything.
    spi_xfer(16'h8177, 16, 0, 10, rd);
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    check_regs("rst_abort_regs");
    check("rst_abort_miso", miso, 1'b0);
    check("rst_abort_wr_valid", wr_valid, 1'b0);
    check("rst_abort_wr_addr", wr_addr, 7'h00);
    check("rst_abort_wr_data", wr_data, 8'h00);

    // Extra clocks after bit 16 are ignored.
    exp_wr.push_back({7'd0, 8'h11});
    model[0] = 8'h11;
    spi_xfer(16'h8011, 16, 8, 0, rd);
    check_regs("drain_regs");
    do_read(7'd0, "rd0");
    do_read(7'd5, "rd5_after_reset");

    repeat (10) @(negedge clk);
    check("pending_writes", exp_wr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 SHALL have one clock and one reset: ports clk and reset; reset is synchronous and active-high.
REQ-002 Parameter NUM_REGS, default 16, SHALL set the number of 8-bit configuration registers (legal range 1..128).
REQ-003 Port clk, input, 1, system clock; all state SHALL change only on its rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port sclk, input, 1, SPI clock, asynchronous to clk, max frequency clk/8.
REQ-006 Port cs_n, input, 1, SPI chip select, active low, asynchronous.
REQ-007 Port mosi, input, 1, SPI controller-out data, asynchronous.
REQ-008 Port miso, output, 1, SPI controller-in data, registered.
REQ-009 Port regs_flat, output, NUM_REGS*8, register contents; register i SHALL occupy bits [8i+7:8i].
REQ-010 Port wr_valid, output, 1, one-clk pulse per committed write.
REQ-011 Port wr_addr, output, 7, address of the committed write; valid while wr_valid=1.
REQ-012 Port wr_data, output, 8, data of the committed write; valid while wr_valid=1.

Function
REQ-013 sclk, cs_n and mosi SHALL each pass a two-flop synchronizer; edge detection SHALL use the synchronized sclk and a third delayed flop.
REQ-014 SPI mode 0: mosi SHALL be sampled on detected sclk rising edges; miso SHALL change only on detected sclk falling edges or on the load event in REQ-019.
REQ-015 Frame = 16 bits, MSB first: bit15 = W (1 write, 0 read), bits14:8 = address, bits7:0 = data.
REQ-016 FSM states: IDLE, CMD (bits 15..8), DATA (bits 7..0), DRAIN; a 4-bit bit counter SHALL track received bits.
REQ-017 Transitions: IDLE->CMD when synchronized cs_n falls; CMD->DATA after the 8th rising edge; DATA->DRAIN after the 16th rising edge; DRAIN->IDLE when synchronized cs_n rises.
REQ-018 Any state SHALL go to IDLE whenever synchronized cs_n is high; a partial frame SHALL be discarded with no register change and no wr_valid.
REQ-019 Read: in the clk cycle after the 8th rising edge with W=0, the shift register SHALL load reg[address] and miso SHALL present its bit7; each falling edge following rising edges 9..15 SHALL shift out the next bit.
REQ-020 Read of address >= NUM_REGS SHALL return 0x00.
REQ-021 Write: in the clk cycle after the 16th rising edge with W=1 and address < NUM_REGS, reg[address] SHALL update, and wr_valid/wr_addr/wr_data SHALL be asserted for exactly that cycle.
REQ-022 Write to address >= NUM_REGS SHALL be ignored: no register change, no wr_valid.
REQ-023 miso SHALL be 0 in IDLE, CMD, DRAIN, during write frames, and whenever cs_n is high.
REQ-024 Bits beyond 16 in one frame (DRAIN) SHALL be ignored; a new frame SHALL require cs_n deasserted then reasserted.
REQ-025 Reads SHALL have no side effects on registers.

Reset
REQ-026 On reset: all registers 0x00, miso 0, wr_valid 0, wr_addr 0, wr_data 0, FSM IDLE, bit counter 0, synchronizer flops set to the idle levels (sclk 0, cs_n 1, mosi 0).
REQ-027 Reset asserted mid-frame SHALL abort the frame; the frame's write SHALL not commit, even if reset deasserts before cs_n rises.

Structure
REQ-028 Shared package snn_pkg SHALL hold SPI_FRAME_BITS=16, SPI_ADDR_W=7, the FSM state enum, and named register address constants.
REQ-029 One sub-module, sync2 (two-flop synchronizer with reset value parameter), SHALL be instantiated three times.

Verification
REQ-030 Write 0x85 0x3C (W=1, addr 5, data 0x3C) -> regs_flat[47:40]=0x3C; one wr_valid pulse with wr_addr=5, wr_data=0x3C.
REQ-031 After REQ-030, read frame 0x05 0x00 -> miso shifts 0x3C MSB first across bits 7..0; regs_flat unchanged.
REQ-032 Write 0x92 0xFF (addr 0x12 >= 16) -> no wr_valid, regs_flat unchanged; a following read of addr 0x12 returns 0x00.
REQ-033 Write 0x83 0xAA with cs_n raised after 12 bits -> reg 3 stays 0x00, no wr_valid; next full write 0x83 0xAA succeeds.
REQ-034 Assert reset for one clk after 10 bits of write 0x81 0x77, then complete the frame -> reg 1 stays 0x00, no wr_valid; all outputs at reset values.
REQ-035 Write 0x80 0x11 followed by 8 extra sclk pulses before cs_n rises -> reg 0=0x11, exactly one wr_valid.
